// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the PWM sequencer blocks.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } breath_state_e;

  // Width that holds any count up to the larger of the two period limits.
  function automatic int unsigned cnt_width(input int unsigned periods_per_step,
                                            input int unsigned hold_periods);
    int unsigned m;
    m = (periods_per_step > hold_periods) ? periods_per_step : hold_periods;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running shadow of the PWM driver counter; flags the last clock of each period.
module pwm_period_timer #(
  parameter int unsigned CNTR_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  logic [CNTR_LEN-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q + CNTR_LEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  assign period_tick = (pcnt_q == '1);

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-ramp sequencer for a PWM driver: duty moves only on period boundaries.
module pwm_breath_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNTR_LEN         = 8,
  parameter int unsigned STEP             = 1,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned HOLD_PERIODS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CNTR_LEN-1:0] max_level,
  output logic [CNTR_LEN-1:0] compare,
  output logic                period_tick,
  output logic                busy,
  output logic                cycle_done
);

  localparam int unsigned CW = cnt_width(PERIODS_PER_STEP, HOLD_PERIODS);
  localparam int unsigned W1 = CNTR_LEN + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(PERIODS_PER_STEP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_PERIODS - 1);
  localparam logic [W1-1:0] STEP_W    = W1'(STEP);

  breath_state_e       state_q, state_d;
  logic [CNTR_LEN-1:0] compare_q, compare_d;
  logic [CNTR_LEN-1:0] peak_q, peak_d;
  logic [CW-1:0]       div_q, div_d;
  logic [CW-1:0]       hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [W1-1:0]       sum;
  logic [CNTR_LEN-1:0] up_val;
  logic [CNTR_LEN-1:0] dn_val;
  logic                div_last;
  logic                hold_last;

  pwm_period_timer #(
    .CNTR_LEN(CNTR_LEN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .period_tick(period_tick)
  );

  always_comb begin
    state_d   = state_q;
    compare_d = compare_q;
    peak_d    = peak_q;
    div_d     = div_q;
    hold_d    = hold_q;
    done_d    = 1'b0;

    // Sum is one bit wider than compare so the clamp sees overflow instead of a wrap.
    sum       = {1'b0, compare_q} + STEP_W;
    up_val    = (sum > {1'b0, peak_q}) ? peak_q : sum[CNTR_LEN-1:0];
    dn_val    = ({1'b0, compare_q} > STEP_W) ? (compare_q - STEP_W[CNTR_LEN-1:0]) : '0;
    div_last  = (div_q == DIV_LAST);
    hold_last = (hold_q == HOLD_LAST);

    if (period_tick) begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            peak_d  = max_level;
            div_d   = '0;
            state_d = UP;
          end
        end
        UP: begin
          if (!en) begin
            div_d   = '0;
            state_d = DOWN;
          end else if (div_last) begin
            div_d     = '0;
            compare_d = up_val;
            if (up_val == peak_q) begin
              hold_d  = '0;
              state_d = HOLD_HI;
            end
          end else begin
            div_d = div_q + CW'(1);
          end
        end
        HOLD_HI: begin
          if (!en || hold_last) begin
            div_d   = '0;
            state_d = DOWN;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
        DOWN: begin
          if (div_last) begin
            div_d     = '0;
            compare_d = dn_val;
            if (dn_val == '0) begin
              hold_d  = '0;
              state_d = en ? HOLD_LO : IDLE;
            end
          end else begin
            div_d = div_q + CW'(1);
          end
        end
        HOLD_LO: begin
          // The breath completes on the final hold tick even if en has just dropped.
          if (hold_last) begin
            done_d = 1'b1;
            if (en) begin
              peak_d  = max_level;
              div_d   = '0;
              state_d = UP;
            end else begin
              state_d = IDLE;
            end
          end else if (!en) begin
            state_d = IDLE;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      compare_q <= '0;
      peak_q    <= '0;
      div_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      compare_q <= compare_d;
      peak_q    <= peak_d;
      div_q     <= div_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign compare    = compare_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl: 16-clock period, STEP=4 (plus a STEP=8 instance).
module tb_pwm_breath_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en8;
  logic [3:0] max_level, max8;
  logic [3:0] compare, compare8;
  logic       tick, tick8;
  logic       busy, busy8;
  logic       done, done8;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pwm_breath_ctrl #(
    .CNTR_LEN(4), .STEP(4), .PERIODS_PER_STEP(1), .HOLD_PERIODS(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .max_level(max_level),
    .compare(compare), .period_tick(tick), .busy(busy), .cycle_done(done)
  );

  pwm_breath_ctrl #(
    .CNTR_LEN(4), .STEP(8), .PERIODS_PER_STEP(1), .HOLD_PERIODS(2)
  ) dut8 (
    .clk(clk), .rst(rst), .en(en8), .max_level(max8),
    .compare(compare8), .period_tick(tick8), .busy(busy8), .cycle_done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs to the next tick edge, then checks the values registered on it.
  task automatic step_period(input string tag, input int exp_cmp, input int exp_busy,
                             input int exp_done);
    int n;
    int moved;
    logic [3:0] c0;
    c0 = compare;
    moved = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (compare !== c0) moved = 1;
      if (tick) break;
      n++;
    end
    chk({tag, "_tick"}, 32'(n < 40), 1);
    chk({tag, "_stable"}, moved, 0);
    chk({tag, "_done_low"}, 32'(done), 0);
    @(posedge clk);
    #1;
    chk({tag, "_cmp"}, 32'(compare), exp_cmp);
    chk({tag, "_busy"}, 32'(busy), exp_busy);
    chk({tag, "_done"}, 32'(done), exp_done);
  endtask

  task automatic count_first_tick(input string tag);
    int n;
    n = 0;
    chk({tag, "_tick_low"}, 32'(tick), 0);
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (tick) break;
    end
    chk({tag, "_first_tick"}, n, 15);
    chk({tag, "_tick8"}, 32'(tick8), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fb[11]   = '{4, 8, 12, 12, 12, 8, 4, 0, 0, 0, 4};
    int sat[10]  = '{4, 8, 10, 10, 10, 6, 2, 0, 0, 0};
    int s8[3]    = '{8, 15, 15};
    int lt1[3]   = '{4, 8, 12};
    int lt2[11]  = '{12, 12, 8, 4, 0, 0, 0, 4, 4, 4, 0};

    rst = 1'b1; en = 1'b0; en8 = 1'b0; max_level = '0; max8 = '0;
    #2;
    chk("rst_cmp", 32'(compare), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);

    repeat (3) @(negedge clk);
    rst = 1'b0; en = 1'b1; max_level = 4'd12;
    count_first_tick("rel1");
    chk("full_start_cmp", 32'(compare), 0);
    chk("full_start_busy", 32'(busy), 1);
    for (int i = 0; i < 11; i++)
      step_period($sformatf("full%0d", i), fb[i], 1, (i == 9) ? 1 : 0);

    // Asynchronous reset mid-ramp (compare is 4 here).
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_cmp", 32'(compare), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; max_level = 4'd10; en8 = 1'b1; max8 = 4'd15;
    count_first_tick("rel2");
    chk("sat_start_cmp", 32'(compare), 0);
    chk("sat8_start_cmp", 32'(compare8), 0);
    chk("sat8_start_busy", 32'(busy8), 1);
    for (int i = 0; i < 10; i++) begin
      step_period($sformatf("sat%0d", i), sat[i], 1, (i == 9) ? 1 : 0);
      if (i < 3) chk($sformatf("sat8_%0d", i), 32'(compare8), s8[i]);
    end
    chk("sat8_done", 32'(done8), 0);

    // Early stop: ramp restarted with peak 10; drop en at compare 8.
    step_period("es_a", 4, 1, 0);
    step_period("es_b", 8, 1, 0);
    en = 1'b0;
    step_period("es_c", 8, 1, 0);
    step_period("es_d", 4, 1, 0);
    step_period("es_e", 0, 0, 0);
    step_period("es_f", 0, 0, 0);

    // Latch: max_level changes during HOLD_HI affect only the next breath.
    en = 1'b1; max_level = 4'd12;
    step_period("lt_start", 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step_period($sformatf("lt1_%0d", i), lt1[i], 1, 0);
    max_level = 4'd4;
    for (int i = 0; i < 11; i++)
      step_period($sformatf("lt2_%0d", i), lt2[i], 1, (i == 6) ? 1 : 0);

    // Zero peak: latched on the pulse at zp1.
    max_level = 4'd0;
    for (int i = 0; i < 8; i++)
      step_period($sformatf("zp%0d", i), 0, 1, (i == 1 || i == 7) ? 1 : 0);
    en = 1'b0;
    step_period("zp_stop_a", 0, 1, 0);
    step_period("zp_stop_b", 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctrl.md
# pwm_breath_ctrl

Sequencer that drives the `compare` input of the team's PWM driver to produce a repeating "breathing" ramp: up to a programmable peak, hold, down to zero, hold. It runs a shadow period counter in lock-step with the driver's counter. It changes `compare` only on the period boundary, so the driver never sees a mid-period duty change. It sits between the control/config logic and one PWM driver instance.

## Interface
Parameters:
- `CNTR_LEN`, 8, PWM counter width; PWM period is 2^CNTR_LEN clocks.
- `STEP`, 1, duty increment/decrement per step, 1..2^CNTR_LEN-1.
- `PERIODS_PER_STEP`, 4, PWM periods between duty steps, ≥1.
- `HOLD_PERIODS`, 16, PWM periods spent at peak and at zero, ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `en`  in  1  level; run breathing while high.
- `max_level`  in  CNTR_LEN  peak duty. Latched when each ramp-up begins.
- `compare`  out  CNTR_LEN  duty value to the PWM driver `compare` input.
- `period_tick`  out  1  high during the last clock of each PWM period (shadow counter = all ones).
- `busy`  out  1  high whenever the state is not IDLE.
- `cycle_done`  out  1  one-clock pulse at the end of each full breath.

## Operation
- Shadow counter `pcnt` (CNTR_LEN bits) is free-running and wraps from 2^CNTR_LEN-1 to 0. The PWM driver must leave reset on the same clock edge so both counters stay aligned.
- A "tick edge" is the clock edge on which `period_tick` is high. All state, `compare`, step-divider and hold-counter updates occur only on tick edges. The single exception is `cycle_done`, which is registered on the tick edge.
- States are IDLE, UP, HOLD_HI, DOWN and HOLD_LO.
- **IDLE**: if `en` is high at a tick edge, latch `max_level` into `peak`, clear the step divider and go to UP. `compare` stays 0.
- **UP**: the step divider counts tick edges. On every PERIODS_PER_STEP-th tick edge, `compare` ← min(`compare`+STEP, `peak`). The sum is computed at CNTR_LEN+1 bits, so it cannot wrap. If the result equals `peak`, go to HOLD_HI and clear the hold counter. If `en` is low at a tick edge, go to DOWN without stepping on that edge.
- **HOLD_HI**: on the HOLD_PERIODS-th tick edge, go to DOWN and clear the divider. If `en` is low at any tick edge, go to DOWN immediately.
- **DOWN**: on every PERIODS_PER_STEP-th tick edge, `compare` ← (`compare` > STEP) ? `compare`-STEP : 0. On reaching 0, go to HOLD_LO if `en` is high, otherwise go to IDLE.
- **HOLD_LO**: on the HOLD_PERIODS-th tick edge, pulse `cycle_done`. If `en` is high, re-latch `max_level` and go to UP; otherwise go to IDLE. If `en` is low at an earlier tick edge, go to IDLE immediately with no `cycle_done`.
- If `peak` = 0, the first step edge in UP leaves `compare` at 0 and goes to HOLD_HI.
- Changes to `max_level` outside the latch point are ignored.
- `en` is sampled only on tick edges; pulses between ticks are lost.

## Timing
- Reset values: `compare`=0, `busy`=0, `cycle_done`=0, `pcnt`=0, state=IDLE, all counters 0.
- `period_tick` is high exactly 1 of every 2^CNTR_LEN clocks, starting at clock 2^CNTR_LEN-1 after reset release.
- `compare` is registered and changes only on the clock following `period_tick`, which is the first clock of the new PWM period.
- `busy` is registered and rises and falls on tick edges.
- Assertion of `rst` mid-ramp returns all outputs to reset values asynchronously. The shadow counter restarts at 0.

## Structure
- Shared package `pwm_pkg`: the state enum (IDLE, UP, HOLD_HI, DOWN, HOLD_LO) and the width helper for the hold counter and divider, $clog2 of max(PERIODS_PER_STEP, HOLD_PERIODS)+1.
- Sub-module `pwm_period_timer`: shadow counter plus `period_tick` generation. It is reusable by other PWM sequencers.
- Top level: FSM, step divider, hold counter, `peak` latch, saturating add/subtract.

## Test plan
All scenarios use CNTR_LEN=4 (16-clock period), STEP=4, PERIODS_PER_STEP=1, HOLD_PERIODS=2.
- **Reset**: assert `rst` asynchronously mid-period. Required: `compare`=0, `busy`=0 and `cycle_done`=0 immediately; first `period_tick` at clock 15 after release.
- **Full breath**: `en`=1, `max_level`=12. Required: `compare` sequence per period 0,4,8,12,12,12,8,4,0,0,0; `cycle_done` pulses once; next ramp starts; `compare` changes only on the clock after `period_tick`.
- **Saturation**: `max_level`=10. Required: sequence 0,4,8,10,10,10,6,2,0. Also set `max_level`=15 with STEP=8. Required: 0,8,15 with no wrap.
- **Early stop**: drop `en` while in UP at `compare`=8. Required: next tick edge goes to DOWN, then 4,0, then IDLE, `busy`=0, no `cycle_done`.
- **Latch**: change `max_level` from 12 to 4 during HOLD_HI. Required: current breath is unaffected; next breath peaks at 4.
- **Zero peak**: `max_level`=0. Required: `compare` stays 0 throughout; `cycle_done` still pulses after the UP step edge, 2 HOLD_HI ticks, DOWN and 2 HOLD_LO ticks.
